// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types, constants and lane helpers for the memory access unit
package mem_pkg;

  localparam int XLEN       = 32;
  localparam int DATA_WIDTH = 3;
  localparam int BE_W       = XLEN / 8;

  typedef enum logic [DATA_WIDTH-1:0] {
    W_B  = 3'b000,
    W_H  = 3'b001,
    W_W  = 3'b010,
    W_BU = 3'b100,
    W_HU = 3'b101
  } width_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  // width[1:0] gives the access size for every legal load and store code
  function automatic logic [BE_W-1:0] be_mask(input logic [DATA_WIDTH-1:0] width,
                                               input logic [1:0]            offset);
    case (width[1:0])
      2'b00:   be_mask = 4'b0001 << offset;
      2'b01:   be_mask = 4'b0011 << offset;
      default: be_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0]       shifted,
                                             input logic [DATA_WIDTH-1:0] width);
    case (width)
      W_B:     extend = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      W_H:     extend = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      W_BU:    extend = {{(XLEN-8){1'b0}}, shifted[7:0]};
      W_HU:    extend = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: extend = shifted;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - combinational load lane shift and sign/zero extension
module mem_load_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0]       rdata,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] width,
  output logic [XLEN-1:0]       rd_data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};
  assign rd_data = extend(shifted, width);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store unit driving a byte-enabled memory bus
module mem_access_unit
  import mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  load_enable,
  input  logic                  store_enable,
  input  logic [XLEN-1:0]       addr,
  input  logic [DATA_WIDTH-1:0] width,
  input  logic [XLEN-1:0]       store_data,
  output logic                  busy,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rd_data,
  output logic                  misaligned,
  output logic                  illegal,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [XLEN-1:0]       mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [BE_W-1:0]       mem_be,
  input  logic                  mem_rsp_valid,
  input  logic [XLEN-1:0]       mem_rdata
);

  state_e                state_q, state_d;
  logic                  is_store_q;
  logic [XLEN-1:0]       addr_q, data_q, rd_data_q;
  logic [DATA_WIDTH-1:0] width_q;
  logic                  mis_q, ill_q;

  logic                  accept, illegal_in, misaligned_in, fault_in, in_req;
  logic [XLEN-1:0]       load_word;

  mem_load_align u_align (
    .rdata   (mem_rdata),
    .addr_lo (addr_q[1:0]),
    .width   (width_q),
    .rd_data (load_word)
  );

  always_comb begin
    accept        = 1'b0;
    illegal_in    = 1'b0;
    misaligned_in = 1'b0;
    accept = (state_q == S_IDLE) && req_valid && (load_enable ^ store_enable);
    if (store_enable) illegal_in = (width > 3'b010);
    else              illegal_in = (width == 3'b011) || (width[2:1] == 2'b11);
    case (width[1:0])
      2'b01:   misaligned_in = addr[0];
      2'b10:   misaligned_in = (addr[1:0] != 2'b00);
      default: misaligned_in = 1'b0;
    endcase
    fault_in = illegal_in || misaligned_in;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (accept) state_d = fault_in ? S_DONE : S_REQ;
      S_REQ:      if (mem_req_ready) state_d = is_store_q ? S_DONE : S_WAIT_RSP;
      S_WAIT_RSP: if (mem_rsp_valid) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      width_q    <= '0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q <= store_enable;
        addr_q     <= addr;
        data_q     <= store_data;
        width_q    <= width;
        ill_q      <= illegal_in;
        mis_q      <= misaligned_in && !illegal_in;
      end
      // result register only changes on entry to DONE; stores and faults return zero
      if (state_d == S_DONE && state_q != S_DONE)
        rd_data_q <= (state_q == S_WAIT_RSP) ? load_word : '0;
    end
  end

  assign in_req        = (state_q == S_REQ);
  assign req_ready     = (state_q == S_IDLE) && !rst;
  assign busy          = (state_q != S_IDLE);
  assign rsp_valid     = (state_q == S_DONE);
  assign misaligned    = rsp_valid && mis_q;
  assign illegal       = rsp_valid && ill_q;
  assign rd_data       = rd_data_q;
  assign mem_req_valid = in_req;
  assign mem_we        = in_req && is_store_q;
  assign mem_addr      = in_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_be        = !in_req ? '0 : (is_store_q ? be_mask(width_q, addr_q[1:0]) : '1);

  always_comb begin
    mem_wdata = '0;
    if (in_req && is_store_q) begin
      case (width_q[1:0])
        2'b00:   mem_wdata = {4{data_q[7:0]}};
        2'b01:   mem_wdata = {2{data_q[15:0]}};
        default: mem_wdata = data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, load_enable, store_enable;
  logic [31:0] addr, store_data;
  logic [2:0]  width;
  logic        req_ready, busy, rsp_valid, misaligned, illegal;
  logic [31:0] rd_data;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .load_enable(load_enable), .store_enable(store_enable), .addr(addr),
    .width(width), .store_data(store_data), .busy(busy), .rsp_valid(rsp_valid),
    .rd_data(rd_data), .misaligned(misaligned), .illegal(illegal),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        st;
    logic [31:0] a;
    logic [2:0]  w;
    logic [31:0] d;
    int          rqw;
    int          rsw;
    logic [31:0] rdat;
    int          lat;
    logic [31:0] rd;
    logic        mis;
    logic        ill;
    logic [3:0]  be;
    logic [31:0] wdata;
  } vec_t;

  vec_t tbl[14];

  // observations from one transaction
  logic        o_rdy0, o_got, o_saw, o_unstable, o_we, o_mis, o_ill, o_after, o_idle;
  int          o_lat;
  logic [31:0] o_rd, o_addr, o_wdata;
  logic [3:0]  o_be;

  // reference expectations
  logic        e_mis, e_ill, e_fault;
  int          e_lat;
  logic [31:0] e_rd, e_addr, e_wdata;
  logic [3:0]  e_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // plays the execute stage and the memory; entered and left 1ns after a rising edge
  task automatic run_txn(input logic st, input logic [31:0] a, input logic [2:0] w,
                         input logic [31:0] d, input int rqw, input int rsw,
                         input logic [31:0] rdat, input logic noise);
    int  req_cnt, rsp_cnt;
    logic hs, snap;
    req_valid = 1'b1; store_enable = st; load_enable = !st;
    addr = a; width = w; store_data = d;
    o_rdy0 = req_ready;
    o_got = 0; o_saw = 0; o_unstable = 0; o_lat = -1; o_rd = 0; o_mis = 0; o_ill = 0;
    o_addr = 0; o_be = 0; o_we = 0; o_wdata = 0;
    req_cnt = 0; rsp_cnt = 0; hs = 0; snap = 0;
    step();
    req_valid = 1'b0; store_enable = 1'b0; load_enable = 1'b0;
    addr = $urandom; store_data = $urandom; width = 3'($urandom);
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (rsp_valid) begin
        o_got = 1; o_lat = cyc; o_rd = rd_data; o_mis = misaligned; o_ill = illegal;
        break;
      end
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      if (mem_req_valid) begin
        o_saw = 1;
        if (!snap) begin
          snap = 1; o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata;
        end else if (mem_addr !== o_addr || mem_be !== o_be || mem_we !== o_we || mem_wdata !== o_wdata)
          o_unstable = 1;
        if (!busy) o_unstable = 1;
        if (noise) mem_rsp_valid = 1'($urandom);
        if (req_cnt >= rqw) begin mem_req_ready = 1'b1; hs = 1; end
        req_cnt++;
      end else if (hs && !st) begin
        if (rsp_cnt >= rsw) begin mem_rsp_valid = 1'b1; mem_rdata = rdat; end
        rsp_cnt++;
      end
      step();
    end
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    step();
    o_after = rsp_valid;
    o_idle  = req_ready;
  endtask

  task automatic check_txn(input logic st, input logic [31:0] a, input logic [31:0] rd,
                           input int lat, input logic mis, input logic ill,
                           input logic [3:0] be, input logic [31:0] wd);
    logic fault;
    fault = mis || ill;
    chk("req_ready_at_accept", 32'(o_rdy0), 32'd1);
    chk("rsp_seen", 32'(o_got), 32'd1);
    chk("latency", 32'(o_lat), 32'(lat));
    chk("rd_data", o_rd, rd);
    chk("misaligned", 32'(o_mis), 32'(mis));
    chk("illegal", 32'(o_ill), 32'(ill));
    chk("mem_req_seen", 32'(o_saw), 32'(!fault));
    if (!fault) begin
      chk("mem_addr", o_addr, a & 32'hFFFF_FFFC);
      chk("mem_be", 32'(o_be), 32'(be));
      chk("mem_we", 32'(o_we), 32'(st));
      if (st) chk("mem_wdata", o_wdata, wd);
      chk("mem_stable_busy", 32'(o_unstable), 32'd0);
    end
    chk("rsp_single_pulse", 32'(o_after), 32'd0);
    chk("back_to_back_ready", 32'(o_idle), 32'd1);
  endtask

  // reference: access rules computed from sizes and plain arithmetic
  task automatic model(input logic st, input logic [31:0] a, input logic [2:0] w,
                       input logic [31:0] d, input int rqw, input int rsw, input logic [31:0] rdat);
    int     sz;
    longint v;
    e_ill   = st ? (w > 2) : !(w == 0 || w == 1 || w == 2 || w == 4 || w == 5);
    sz      = (w % 4 == 0) ? 1 : ((w % 4 == 1) ? 2 : 4);
    e_mis   = !e_ill && (a % sz != 0);
    e_fault = e_ill || e_mis;
    e_rd = 0; e_be = 4'hF; e_wdata = 0;
    if (e_fault) e_lat = 1;
    else if (st) begin
      e_lat = 2 + rqw;
      e_be  = (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << (a % 4));
      e_wdata = (sz == 1) ? (d % 256) * 32'h0101_0101 :
                (sz == 2) ? (d % 65536) * 32'h0001_0001 : d;
    end else begin
      e_lat = 3 + rqw + rsw;
      v = longint'(rdat) / (longint'(1) << (8 * (a % 4)));
      if (sz < 4) begin
        v = v % (longint'(1) << (8 * sz));
        if (w < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      end
      e_rd = 32'(v);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 0; load_enable = 0; store_enable = 0;
    addr = 0; width = 0; store_data = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;

    tbl[0]  = '{1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 0, 0, 32'h0,      2, 32'h0,        0, 0, 4'hF, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 32'h103, 3'b000, 32'h000000A5, 0, 0, 32'h0,      2, 32'h0,        0, 0, 4'h8, 32'hA5A5A5A5};
    tbl[2]  = '{1'b0, 32'h102, 3'b000, 32'h0,        0, 2, 32'h12803456, 5, 32'hFFFFFF80, 0, 0, 4'hF, 32'h0};
    tbl[3]  = '{1'b0, 32'h102, 3'b100, 32'h0,        0, 2, 32'h12803456, 5, 32'h00000080, 0, 0, 4'hF, 32'h0};
    tbl[4]  = '{1'b0, 32'h101, 3'b001, 32'h0,        0, 0, 32'h0,      1, 32'h0,        1, 0, 4'h0, 32'h0};
    tbl[5]  = '{1'b1, 32'h100, 3'b100, 32'h11223344, 0, 0, 32'h0,      1, 32'h0,        0, 1, 4'h0, 32'h0};
    tbl[6]  = '{1'b1, 32'h204, 3'b010, 32'h01234567, 4, 0, 32'h0,      6, 32'h0,        0, 0, 4'hF, 32'h01234567};
    tbl[7]  = '{1'b0, 32'h10C, 3'b010, 32'h0,        1, 1, 32'hCAFEF00D, 5, 32'hCAFEF00D, 0, 0, 4'hF, 32'h0};
    tbl[8]  = '{1'b0, 32'h202, 3'b101, 32'h0,        0, 0, 32'h80011234, 3, 32'h00008001, 0, 0, 4'hF, 32'h0};
    tbl[9]  = '{1'b0, 32'h202, 3'b001, 32'h0,        2, 0, 32'h80011234, 5, 32'hFFFF8001, 0, 0, 4'hF, 32'h0};
    tbl[10] = '{1'b1, 32'h202, 3'b001, 32'h1234ABCD, 0, 0, 32'h0,      2, 32'h0,        0, 0, 4'hC, 32'hABCDABCD};
    tbl[11] = '{1'b0, 32'h003, 3'b011, 32'h0,        0, 0, 32'h0,      1, 32'h0,        0, 1, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 32'h102, 3'b010, 32'h0,        0, 0, 32'h0,      1, 32'h0,        1, 0, 4'h0, 32'h0};
    tbl[13] = '{1'b1, 32'h101, 3'b001, 32'h0,        0, 0, 32'h0,      1, 32'h0,        1, 0, 4'h0, 32'h0};

    step(); step();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    step();

    for (int i = 0; i < 14; i++) begin
      run_txn(tbl[i].st, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].rqw, tbl[i].rsw, tbl[i].rdat, 1'b0);
      check_txn(tbl[i].st, tbl[i].a, tbl[i].rd, tbl[i].lat, tbl[i].mis, tbl[i].ill, tbl[i].be, tbl[i].wdata);
    end

    // requests with neither or both enables are ignored
    req_valid = 1'b1; load_enable = 1'b1; store_enable = 1'b1; addr = 32'h40; width = 3'b010;
    step();
    chk("both_enables_busy", 32'(busy), 32'd0);
    chk("both_enables_memreq", 32'(mem_req_valid), 32'd0);
    load_enable = 1'b0; store_enable = 1'b0;
    step();
    chk("no_enable_busy", 32'(busy), 32'd0);
    chk("no_enable_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    step();

    // reset abort during WAIT_RSP with a late response
    req_valid = 1'b1; load_enable = 1'b1; addr = 32'h40; width = 3'b010;
    step();
    req_valid = 1'b0; load_enable = 1'b0;
    chk("abort_in_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("abort_wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'h5555_AAAA;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    step();
    mem_rsp_valid = 1'b0;
    chk("abort_late_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_late_busy", 32'(busy), 32'd0);
    chk("abort_rd_data", rd_data, 32'd0);

    for (int n = 0; n < 200; n++) begin
      logic        st;
      logic [31:0] a, d, rdat;
      logic [2:0]  w;
      int          rqw, rsw;
      st = 1'($urandom); a = $urandom; d = $urandom; rdat = $urandom;
      w = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) w = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      if (w == 3'b011 && !st && $urandom_range(0, 1) == 1) w = 3'b100;
      rqw = $urandom_range(0, 3); rsw = $urandom_range(0, 3);
      model(st, a, w, d, rqw, rsw, rdat);
      run_txn(st, a, w, d, rqw, rsw, rdat, 1'b1);
      check_txn(st, a, e_rd, e_lat, e_mis, e_ill, e_be, e_wdata);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
